// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types for the core memory ports.
//   mem_req_t  - request payload (addr, wen, strb, wdata); req itself travels separately
//   mem_rsp_t  - response (gnt, err, rdata)
//   arb_lock_t - arbiter ownership; FREE doubles as "no owner" on the pick output
package core_mem_pkg;

  localparam int CORE_MEM_ADDR_W = 64;
  localparam int CORE_MEM_STRB_W = 8;
  localparam int CORE_MEM_DATA_W = 64;

  typedef struct packed {
    logic [CORE_MEM_ADDR_W-1:0] addr;
    logic                       wen;
    logic [CORE_MEM_STRB_W-1:0] strb;
    logic [CORE_MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                       gnt;
    logic                       err;
    logic [CORE_MEM_DATA_W-1:0] rdata;
  } mem_rsp_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_lock_t;

endpackage

// File: rtl/core_mem_arb_pick.sv
// core_mem_arb_pick: combinational owner selection for core_mem_arbiter.
//   i_lock      - current lock state (held owner while a transaction waits)
//   i_imem_req  - imem request
//   i_dmem_req  - dmem request
//   i_starved   - starvation counter has reached its limit
//   o_owner     - chosen owner; FREE means nobody drives the shared port
module core_mem_arb_pick
  import core_mem_pkg::*;
(
  input  arb_lock_t i_lock,
  input  logic      i_imem_req,
  input  logic      i_dmem_req,
  input  logic      i_starved,
  output arb_lock_t o_owner
);

  always_comb begin
    o_owner = FREE;
    if (i_lock != FREE)
      o_owner = i_lock;
    // dmem has priority unless imem has been passed over too many times
    else if (i_dmem_req && !(i_imem_req && i_starved))
      o_owner = OWN_D;
    else if (i_imem_req)
      o_owner = OWN_I;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory port between core imem and dmem.
//   g_clk, g_reset           - clock, async active-high reset
//   imem_* / dmem_*          - requester ports (req/addr/wen/strb/wdata in, gnt/err/rdata out)
//   smem_*                   - shared downstream port (req/payload out, gnt/err/rdata in)
// Requests are muxed through with no added latency; the owner is locked from
// the first unanswered req until its gnt. dmem has fixed priority, with imem
// forced through after STARVE_LIMIT consecutive dmem grants while it waited.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int MEM_ADDR_W   = CORE_MEM_ADDR_W,
  parameter int MEM_STRB_W   = CORE_MEM_STRB_W,
  parameter int MEM_DATA_W   = CORE_MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  smem_req,
  output logic [MEM_ADDR_W-1:0] smem_addr,
  output logic                  smem_wen,
  output logic [MEM_STRB_W-1:0] smem_strb,
  output logic [MEM_DATA_W-1:0] smem_wdata,
  input  logic                  smem_gnt,
  input  logic                  smem_err,
  input  logic [MEM_DATA_W-1:0] smem_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  // The payload structs are sized by the package; refuse mismatched overrides.
  if (MEM_ADDR_W != CORE_MEM_ADDR_W || MEM_STRB_W != CORE_MEM_STRB_W ||
      MEM_DATA_W != CORE_MEM_DATA_W) begin : g_width_chk
    $error("core_mem_arbiter: widths must match core_mem_pkg");
  end

  arb_lock_t      r_lock;
  logic [SCW-1:0] r_starve;
  arb_lock_t      w_owner;
  logic           w_starved;
  mem_req_t       w_ireq, w_dreq, w_sreq;
  mem_rsp_t       w_srsp, w_irsp, w_drsp;

  assign w_starved = (r_starve == STARVE_MAX);

  core_mem_arb_pick u_pick (
    .i_lock     (r_lock),
    .i_imem_req (imem_req),
    .i_dmem_req (dmem_req),
    .i_starved  (w_starved),
    .o_owner    (w_owner)
  );

  // request path
  assign w_ireq = '{addr: imem_addr, wen: imem_wen, strb: imem_strb, wdata: imem_wdata};
  assign w_dreq = '{addr: dmem_addr, wen: dmem_wen, strb: dmem_strb, wdata: dmem_wdata};

  always_comb begin
    w_sreq = '0;
    if (w_owner == OWN_I)      w_sreq = w_ireq;
    else if (w_owner == OWN_D) w_sreq = w_dreq;
  end

  assign smem_req   = !g_reset && (w_owner != FREE);
  assign smem_addr  = w_sreq.addr;
  assign smem_wen   = w_sreq.wen;
  assign smem_strb  = w_sreq.strb;
  assign smem_wdata = w_sreq.wdata;

  // response path: only the owner sees the response, everyone else sees zeros
  assign w_srsp = '{gnt: smem_gnt, err: smem_err, rdata: smem_rdata};

  always_comb begin
    w_irsp = '0;
    w_drsp = '0;
    if (w_owner == OWN_I)      w_irsp = w_srsp;
    else if (w_owner == OWN_D) w_drsp = w_srsp;
  end

  assign imem_gnt   = w_irsp.gnt && !g_reset;
  assign imem_err   = w_irsp.err;
  assign imem_rdata = w_irsp.rdata;
  assign dmem_gnt   = w_drsp.gnt && !g_reset;
  assign dmem_err   = w_drsp.err;
  assign dmem_rdata = w_drsp.rdata;

  // lock + starvation state
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_lock   <= FREE;
      r_starve <= '0;
    end else begin
      if (smem_gnt)
        r_lock <= FREE;
      else if (smem_req)
        r_lock <= w_owner;

      if (smem_gnt) begin
        if (w_owner == OWN_D && imem_req) begin
          if (!w_starved) r_starve <= r_starve + 1'b1;
        end else if (w_owner == OWN_I) begin
          r_starve <= '0;
        end
      end
    end
  end

  // A locked owner must keep its request up until it is granted.
  a_imem_hold: assert property (@(posedge g_clk) disable iff (g_reset)
    (r_lock == OWN_I) |-> imem_req);
  a_dmem_hold: assert property (@(posedge g_clk) disable iff (g_reset)
    (r_lock == OWN_D) |-> dmem_req);

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;
  import core_mem_pkg::*;

  logic        g_clk, g_reset;
  logic        imem_req, imem_wen, imem_gnt, imem_err;
  logic [63:0] imem_addr, imem_wdata, imem_rdata;
  logic [7:0]  imem_strb;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;
  logic        smem_req, smem_wen, smem_gnt, smem_err;
  logic [63:0] smem_addr, smem_wdata, smem_rdata;
  logic [7:0]  smem_strb;

  int n_tests = 0;
  int n_fail  = 0;

  core_mem_arbiter dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_strb(imem_strb), .imem_wdata(imem_wdata), .imem_gnt(imem_gnt),
    .imem_err(imem_err), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .smem_req(smem_req), .smem_addr(smem_addr), .smem_wen(smem_wen),
    .smem_strb(smem_strb), .smem_wdata(smem_wdata), .smem_gnt(smem_gnt),
    .smem_err(smem_err), .smem_rdata(smem_rdata)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are checked on the falling edge
  task automatic next_cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_all();
    imem_req = 0; imem_addr = '0; imem_wen = 0; imem_strb = '0; imem_wdata = '0;
    dmem_req = 0; dmem_addr = '0; dmem_wen = 0; dmem_strb = '0; dmem_wdata = '0;
    smem_gnt = 0; smem_err = 0; smem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    g_reset = 1;
    idle_all();
    repeat (2) next_cyc();
    g_reset = 0;

    // 1. idle after reset
    @(negedge g_clk);
    chk("idle smem_req", 64'(smem_req), 64'd0);
    chk("idle imem_gnt", 64'(imem_gnt), 64'd0);
    chk("idle dmem_gnt", 64'(dmem_gnt), 64'd0);
    chk("idle lock",     64'(dut.r_lock), 64'(FREE));
    chk("idle starve",   64'(dut.r_starve), 64'd0);

    // 2. zero-wait imem read
    next_cyc();
    imem_req = 1; imem_addr = 64'h80; smem_gnt = 1; smem_rdata = 64'hDEAD;
    @(negedge g_clk);
    chk("zw smem_req",   64'(smem_req), 64'd1);
    chk("zw smem_addr",  smem_addr, 64'h80);
    chk("zw imem_gnt",   64'(imem_gnt), 64'd1);
    chk("zw imem_rdata", imem_rdata, 64'hDEAD);
    chk("zw dmem_gnt",   64'(dmem_gnt), 64'd0);
    chk("zw dmem_rdata", dmem_rdata, 64'd0);
    next_cyc();
    chk("zw lock", 64'(dut.r_lock), 64'(FREE));
    idle_all();

    // 3. simultaneous requests, dmem wins, gnt two cycles later
    imem_req = 1; imem_addr = 64'h100;
    dmem_req = 1; dmem_addr = 64'h200; dmem_wen = 1; dmem_strb = 8'hF0; dmem_wdata = 64'h55;
    @(negedge g_clk);
    chk("sim t0 addr",  smem_addr, 64'h200);
    chk("sim t0 wen",   64'(smem_wen), 64'd1);
    chk("sim t0 strb",  64'(smem_strb), 64'hF0);
    chk("sim t0 wdata", smem_wdata, 64'h55);
    chk("sim t0 igsnt", 64'(imem_gnt), 64'd0);
    next_cyc();
    chk("sim t1 lock", 64'(dut.r_lock), 64'(OWN_D));
    @(negedge g_clk);
    chk("sim t1 addr", smem_addr, 64'h200);
    next_cyc();
    smem_gnt = 1; smem_err = 1; smem_rdata = 64'h1234;
    @(negedge g_clk);
    chk("sim t2 addr",  smem_addr, 64'h200);
    chk("sim t2 dgnt",  64'(dmem_gnt), 64'd1);
    chk("sim t2 derr",  64'(dmem_err), 64'd1);
    chk("sim t2 drd",   dmem_rdata, 64'h1234);
    chk("sim t2 ignt",  64'(imem_gnt), 64'd0);
    chk("sim t2 ierr",  64'(imem_err), 64'd0);
    chk("sim t2 ird",   imem_rdata, 64'd0);
    next_cyc();
    dmem_req = 0; dmem_wen = 0; smem_gnt = 0; smem_err = 0; smem_rdata = '0;
    chk("sim t3 lock",   64'(dut.r_lock), 64'(FREE));
    chk("sim t3 starve", 64'(dut.r_starve), 64'd1);
    @(negedge g_clk);
    chk("sim t3 addr", smem_addr, 64'h100);
    chk("sim t3 wen",  64'(smem_wen), 64'd0);
    next_cyc();
    smem_gnt = 1;
    @(negedge g_clk);
    chk("sim t4 ignt", 64'(imem_gnt), 64'd1);
    next_cyc();
    chk("sim t5 starve", 64'(dut.r_starve), 64'd0);
    idle_all();

    // 4. starvation override after four dmem wins
    imem_req = 1; imem_addr = 64'h300; dmem_req = 1; smem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      dmem_addr = 64'h400 + 64'(k);
      @(negedge g_clk);
      chk($sformatf("stv d%0d dgnt", k), 64'(dmem_gnt), 64'd1);
      chk($sformatf("stv d%0d ignt", k), 64'(imem_gnt), 64'd0);
      chk($sformatf("stv d%0d addr", k), smem_addr, 64'h400 + 64'(k));
      next_cyc();
      chk($sformatf("stv d%0d cnt", k), 64'(dut.r_starve), 64'(k + 1));
    end
    @(negedge g_clk);
    chk("stv force addr", smem_addr, 64'h300);
    chk("stv force ignt", 64'(imem_gnt), 64'd1);
    chk("stv force dgnt", 64'(dmem_gnt), 64'd0);
    next_cyc();
    chk("stv cnt clr", 64'(dut.r_starve), 64'd0);
    imem_req = 0;
    @(negedge g_clk);
    chk("stv d back", 64'(dmem_gnt), 64'd1);
    next_cyc();
    idle_all();

    // 5. lock hold while imem arrives
    dmem_req = 1; dmem_addr = 64'h500;
    @(negedge g_clk);
    chk("lk t0 addr", smem_addr, 64'h500);
    next_cyc();
    imem_req = 1; imem_addr = 64'h600;
    @(negedge g_clk);
    chk("lk t1 addr", smem_addr, 64'h500);
    chk("lk t1 ignt", 64'(imem_gnt), 64'd0);
    next_cyc();
    @(negedge g_clk);
    chk("lk t2 addr", smem_addr, 64'h500);
    next_cyc();
    smem_gnt = 1;
    @(negedge g_clk);
    chk("lk t3 dgnt", 64'(dmem_gnt), 64'd1);
    chk("lk t3 ignt", 64'(imem_gnt), 64'd0);
    next_cyc();
    dmem_req = 0; smem_gnt = 0;
    @(negedge g_clk);
    chk("lk t4 addr", smem_addr, 64'h600);

    // 6. reset while imem owns and waits
    next_cyc();
    chk("rst pre lock",   64'(dut.r_lock), 64'(OWN_I));
    chk("rst pre starve", 64'(dut.r_starve), 64'd1);
    #2;
    g_reset = 1; smem_gnt = 1;
    #1;
    chk("rst smem_req", 64'(smem_req), 64'd0);
    chk("rst imem_gnt", 64'(imem_gnt), 64'd0);
    chk("rst lock",     64'(dut.r_lock), 64'(FREE));
    chk("rst starve",   64'(dut.r_starve), 64'd0);
    next_cyc();
    g_reset = 0;
    idle_all();
    @(negedge g_clk);
    chk("post smem_req", 64'(smem_req), 64'd0);
    chk("post lock",     64'(dut.r_lock), 64'(FREE));
    chk("post starve",   64'(dut.r_starve), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
